// File: rtl/router_pkt_source.sv
//==============================================================================
// router_pkt_source: self-running packet generator for the 1x3 router input.
// Sends header, LFSR payload and XOR parity, and stalls while busy is high.
// Revision: 1.0
//==============================================================================
`default_nettype none

module router_pkt_source #(
  parameter logic [7:0]  LFSR_POLY  = 8'h1D,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic [7:0] seed,
  input  logic       inject_err,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       active,
  output logic       done,
  output logic       req_err,
  output logic [7:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d;
  logic [7:0] seed_q, seed_d;
  logic       err_q, err_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] par_q, par_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       req_err_q, req_err_d;
  logic [7:0] count_q, count_d;
  logic [7:0] par_x;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? LFSR_POLY : 8'h00);
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    seed_d    = seed_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    gap_d     = gap_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    done_d    = 1'b0;
    req_err_d = 1'b0;
    count_d   = count_q;
    par_x     = par_q ^ data_q;

    case (state_q)
      S_IDLE: begin
        if (start && !busy) begin
          if (dest_addr == 2'b11 || payload_len == 6'd0) begin
            req_err_d = 1'b1;
          end else begin
            addr_d   = dest_addr;
            len_d    = payload_len;
            seed_d   = (seed == 8'h00) ? 8'h01 : seed;
            err_d    = inject_err;
            state_d  = S_HEADER;
            data_d   = {payload_len, dest_addr};
            valid_d  = 1'b1;
            active_d = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          par_d   = data_q;
          state_d = S_PAYLOAD;
          data_d  = seed_q;
          cnt_d   = 6'd1;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          par_d = par_x;
          if (cnt_q == len_q) begin
            state_d = S_PARITY;
            data_d  = par_x ^ {7'b0, err_q};
            valid_d = 1'b0;
          end else begin
            data_d = lfsr_next(data_q);
            cnt_d  = cnt_q + 6'd1;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          done_d   = 1'b1;
          count_d  = count_q + 8'd1;
          active_d = 1'b0;
          data_d   = 8'h00;
          gap_d    = 4'd1;
          state_d  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      seed_q    <= 8'h00;
      err_q     <= 1'b0;
      cnt_q     <= 6'd0;
      par_q     <= 8'h00;
      gap_q     <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      req_err_q <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      seed_q    <= seed_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      done_q    <= done_d;
      req_err_q <= req_err_d;
      count_q   <= count_d;
    end
  end

  assign data_out  = data_q;
  assign pkt_valid = valid_q;
  assign active    = active_q;
  assign done      = done_q;
  assign req_err   = req_err_q;
  assign pkt_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_source.sv
//==============================================================================
// tb_router_pkt_source: vector table, corner sequences and random packets
// checked against a byte-list model of the packet format.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_router_pkt_source;

  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       resetn, start, inject_err, busy;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] seed;
  logic [7:0] data_out, pkt_count;
  logic       pkt_valid, active, done, req_err;

  router_pkt_source #(.LFSR_POLY(8'h1D), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .resetn(resetn), .start(start), .dest_addr(dest_addr),
    .payload_len(payload_len), .seed(seed), .inject_err(inject_err), .busy(busy),
    .data_out(data_out), .pkt_valid(pkt_valid), .active(active), .done(done),
    .req_err(req_err), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_count;
  logic [7:0] cap_first, cap_last;

  typedef struct {
    logic [1:0] a;
    logic [5:0] l;
    logic [7:0] s;
    logic       e;
    logic [7:0] hdr;
    logic [7:0] par;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Expected accepted-byte list: header, payload, parity.
  task automatic build_model(input logic [1:0] a, input logic [5:0] l,
                             input logic [7:0] s, input logic e);
    logic [7:0] p, x;
    exp_q.delete();
    exp_q.push_back({l, a});
    x = {l, a};
    p = (s == 8'h00) ? 8'h01 : s;
    for (int k = 1; k <= int'(l); k++) begin
      exp_q.push_back(p);
      x = x ^ p;
      p = lfsr(p);
    end
    exp_q.push_back(x ^ {7'b0, e});
  endtask

  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] s, input logic e);
    dest_addr = a; payload_len = l; seed = s; inject_err = e;
    busy = 1'b0; start = 1'b1;
    build_model(a, l, s, e);
  endtask

  // Starts at the sample showing the header; ends at the sample after parity acceptance.
  task automatic collect(input int mode, output int actc, output int twoc);
    int idx = 0, budget = 0, hold = 3, done_early = 0;
    logic pbusy = 1'b0, pvalid = 1'b0;
    logic [7:0] pdata = 8'h00;
    actc = 0; twoc = 0;
    while (idx < exp_q.size() && budget < 2000) begin
      budget++;
      if (active) begin
        actc++;
        if (pbusy) begin
          chk("hold_data", data_out, pdata);
          chk("hold_valid", pkt_valid, pvalid);
        end
        if (data_out == 8'h02) twoc++;
      end
      if (done) done_early++;
      case (mode)
        1: busy = ($urandom_range(0, 3) == 0);
        2: if (active && data_out == 8'h02 && hold > 0) begin busy = 1'b1; hold--; end
           else busy = 1'b0;
        default: busy = 1'b0;
      endcase
      if (active && !busy) begin
        chk("byte", data_out, exp_q[idx]);
        chk("byte_valid", pkt_valid, (idx < exp_q.size() - 1));
        if (idx == 0) cap_first = data_out;
        cap_last = data_out;
        idx++;
      end
      pbusy = busy; pdata = data_out; pvalid = pkt_valid;
      @(negedge clock);
    end
    chk("pkt_complete", idx, exp_q.size());
    busy = 1'b0;
    exp_count = exp_count + 8'd1;
    chk("done", done, 1);
    chk("active_off", active, 0);
    chk("pkt_count", pkt_count, exp_count);
    chk("done_early", done_early, 0);
  endtask

  task automatic run_packet(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                            input logic e, input int mode, output int actc, output int twoc);
    repeat (GAP + 1) @(negedge clock);
    start_pkt(a, l, s, e);
    @(negedge clock);
    start = 1'b0;
    collect(mode, actc, twoc);
  endtask

  task automatic illegal_req(input logic [1:0] a, input logic [5:0] l);
    repeat (GAP + 1) @(negedge clock);
    dest_addr = a; payload_len = l; seed = 8'h11; inject_err = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("req_err_pulse", req_err, 1);
    chk("req_err_valid", pkt_valid, 0);
    chk("req_err_active", active, 0);
    @(negedge clock);
    chk("req_err_clear", req_err, 0);
    chk("req_err_count", pkt_count, exp_count);
  endtask

  initial begin
    int actc, twoc;
    logic [1:0] ra;
    logic [5:0] rl;

    tbl[0] = '{a: 2'd1, l: 6'd4, s: 8'h01, e: 1'b0, hdr: 8'h11, par: 8'h1E};
    tbl[1] = '{a: 2'd0, l: 6'd9, s: 8'h00, e: 1'b0, hdr: 8'h24, par: 8'hC6};
    tbl[2] = '{a: 2'd1, l: 6'd4, s: 8'h01, e: 1'b1, hdr: 8'h11, par: 8'h1F};
    tbl[3] = '{a: 2'd2, l: 6'd1, s: 8'h80, e: 1'b0, hdr: 8'h06, par: 8'h86};
    tbl[4] = '{a: 2'd0, l: 6'd2, s: 8'h80, e: 1'b0, hdr: 8'h08, par: 8'h95};

    resetn = 1'b0; start = 1'b0; busy = 1'b0; inject_err = 1'b0;
    dest_addr = 2'd0; payload_len = 6'd0; seed = 8'h00;
    exp_count = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_data", data_out, 0);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_count", pkt_count, 0);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_packet(tbl[i].a, tbl[i].l, tbl[i].s, tbl[i].e, 0, actc, twoc);
      chk("tbl_hdr", cap_first, tbl[i].hdr);
      chk("tbl_parity", cap_last, tbl[i].par);
      chk("tbl_active_cycles", actc, int'(tbl[i].l) + 2);
    end

    // 0x02 stalled for three cycles
    run_packet(2'd1, 6'd4, 8'h01, 1'b0, 2, actc, twoc);
    chk("stall_0x02_samples", twoc, 4);
    chk("stall_active_cycles", actc, 9);
    chk("stall_parity", cap_last, 8'h1E);

    // start held high through the gap is ignored until IDLE
    start_pkt(2'd2, 6'd3, 8'h33, 1'b0);
    @(negedge clock);
    chk("gap1_active", active, 0);
    chk("gap1_done", done, 0);
    @(negedge clock);
    chk("gap2_active", active, 0);
    chk("gap2_valid", pkt_valid, 0);
    @(negedge clock);
    chk("gap_end_active", active, 1);
    start = 1'b0;
    collect(0, actc, twoc);

    illegal_req(2'b11, 6'd5);
    illegal_req(2'b01, 6'd0);

    // reset in the middle of payload byte 3
    repeat (GAP + 1) @(negedge clock);
    start_pkt(2'd2, 6'd10, 8'h5A, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_pre_rst_byte", data_out, exp_q[3]);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    exp_count = 8'h00;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_valid", pkt_valid, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_count", pkt_count, 0);
    @(negedge clock);
    chk("post_rst_idle", active, 0);
    run_packet(2'd2, 6'd10, 8'h5A, 1'b0, 0, actc, twoc);
    chk("post_rst_active_cycles", actc, 12);

    run_packet(2'd1, 6'd63, 8'hAB, 1'b0, 0, actc, twoc);
    chk("len63_active_cycles", actc, 65);

    for (int i = 0; i < 20; i++) begin
      ra = 2'($urandom_range(0, 2));
      rl = 6'($urandom_range(1, 63));
      run_packet(ra, rl, 8'($urandom), 1'($urandom), 1, actc, twoc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
